id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus execute-operand forwarding. Feeds the EX-stage ALU (alu_input_1, alu_input_2, 3-bit alu_control) directly.
- Captures decoded instruction state each cycle and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Detects load-use hazards and inserts a bubble into EX, telling ID/IF to hold.

---
 rtl/id_ex_operand_stage_if.sv | 84 ++++++++
 rtl/id_ex_operand_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_if
//
// Bundles every non-clock, non-reset signal of the ID/EX operand stage.
//   ID side      : id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1,
//                  id_rs2, id_rd, id_alu_control, id_src_a_pc, id_src_b_imm,
//                  id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump
//   Pipe control : stall (freeze), flush (kill the slot entering EX)
//   Forwarding   : exm_reg_write/exm_rd/exm_result, mwb_reg_write/mwb_rd/mwb_result
//   EX side      : alu_input_1, alu_input_2, alu_control, ex_store_data,
//                  ex_pc, ex_imm, ex_rd, ex_valid, ex_reg_write, ex_mem_read,
//                  ex_mem_write, ex_branch, ex_jump, hold_front
//
// master : the surrounding pipeline (drives ID/forwarding, consumes EX side)
// slave  : the operand stage itself
// ----------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [2:0]            id_alu_control;
  logic                  id_src_a_pc;
  logic                  id_src_b_imm;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_branch;
  logic                  id_jump;

  logic                  stall;
  logic                  flush;

  logic                  exm_reg_write;
  logic [REG_ADDR_W-1:0] exm_rd;
  logic [XLEN-1:0]       exm_result;
  logic                  mwb_reg_write;
  logic [REG_ADDR_W-1:0] mwb_rd;
  logic [XLEN-1:0]       mwb_result;

  logic [XLEN-1:0]       alu_input_1;
  logic [XLEN-1:0]       alu_input_2;
  logic [2:0]            alu_control;
  logic [XLEN-1:0]       ex_store_data;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  hold_front;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_control, id_src_a_pc, id_src_b_imm, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump,
           stall, flush,
           exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
    input  alu_input_1, alu_input_2, alu_control, ex_store_data, ex_pc, ex_imm,
           ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_jump, hold_front
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_control, id_src_a_pc, id_src_b_imm, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump,
           stall, flush,
           exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
    output alu_input_1, alu_input_2, alu_control, ex_store_data, ex_pc, ex_imm,
           ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_jump, hold_front
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register with EX-operand forwarding and load-use bubbling.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - id_ex_operand_stage_if.slave (ID inputs, stall/flush, forwarding
//          sources, EX-side outputs and hold_front)
//
// Edge priority: flush > stall > load-use bubble > normal capture.
// Forwarding: EX/MEM beats MEM/WB; register x0 is never forwarded.
// ----------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  logic                  ex_valid;
  ctrl_t                 ex_ctrl;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_imm;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [2:0]            ex_alu_control;
  logic                  ex_src_a_pc;
  logic                  ex_src_b_imm;

  ctrl_t                 id_ctrl;
  logic                  load_use;
  logic                  bubble;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;

  assign id_ctrl = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                    bus.id_branch, bus.id_jump};

  // Conservative: rs2 is compared even for instructions that do not read it.
  assign load_use = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && bus.id_valid &&
                    ((ex_rd == bus.id_rs1) || (ex_rd == bus.id_rs2));

  // A flush kills the slot even while stalled, so it must not wait for the freeze.
  assign bubble = bus.flush || (!bus.stall && load_use);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: data registers are reset too; they feed the outputs directly and a
    // known value after reset keeps them free of X.
    if (!rst) begin
      ex_valid       <= 1'b0;
      ex_ctrl        <= '0;
      ex_pc          <= '0;
      ex_imm         <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_alu_control <= '0;
      ex_src_a_pc    <= 1'b0;
      ex_src_b_imm   <= 1'b0;
    end else if (bubble) begin
      // Data registers are don't-care in a bubble; leaving them untouched
      // avoids needless toggling.
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!bus.stall) begin
      ex_valid       <= bus.id_valid;
      ex_ctrl        <= bus.id_valid ? id_ctrl : '0;
      ex_pc          <= bus.id_pc;
      ex_imm         <= bus.id_imm;
      ex_rs1_data    <= bus.id_rs1_data;
      ex_rs2_data    <= bus.id_rs2_data;
      ex_rs1         <= bus.id_rs1;
      ex_rs2         <= bus.id_rs2;
      ex_rd          <= bus.id_rd;
      ex_alu_control <= bus.id_alu_control;
      ex_src_a_pc    <= bus.id_src_a_pc;
      ex_src_b_imm   <= bus.id_src_b_imm;
    end
  end

  // NOTE: defaults first so every path assigns each output and no latch forms.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    fwd_rs2 = ex_rs2_data;
    // EX/MEM holds the youngest value and is checked first.
    if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == ex_rs1)) begin
      fwd_rs1 = bus.exm_result;
    end else if (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == ex_rs1)) begin
      fwd_rs1 = bus.mwb_result;
    end
    if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == ex_rs2)) begin
      fwd_rs2 = bus.exm_result;
    end else if (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == ex_rs2)) begin
      fwd_rs2 = bus.mwb_result;
    end
  end

  assign bus.alu_input_1   = ex_src_a_pc  ? ex_pc  : fwd_rs1;
  assign bus.alu_input_2   = ex_src_b_imm ? ex_imm : fwd_rs2;
  // Stores always need the real rs2 value, even when operand B is the offset.
  assign bus.ex_store_data = fwd_rs2;
  assign bus.alu_control   = ex_alu_control;
  assign bus.ex_pc         = ex_pc;
  assign bus.ex_imm        = ex_imm;
  assign bus.ex_rd         = ex_rd;
  assign bus.ex_valid      = ex_valid;
  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_read   = ex_ctrl.mem_read;
  assign bus.ex_mem_write  = ex_ctrl.mem_write;
  assign bus.ex_branch     = ex_ctrl.branch;
  assign bus.ex_jump       = ex_ctrl.jump;
  assign bus.hold_front    = load_use && !bus.flush;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Drives ID instructions into id_ex_operand_stage, pushes the expected EX-side
// view of each one to a queue when it is driven and pops/compares it one
// edge later. Combinational paths (forwarding, hold_front, async reset) are
// compared directly against hand-derived constants.
// ----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

  logic clk;
  logic rst;

  id_ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hold;   // hold_front before the edge
    logic        valid;  // ex_valid after the edge
    logic [4:0]  ctrl;   // {reg_write, mem_read, mem_write, branch, jump}
    logic        chk;    // compare data fields (0 for bubbles)
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] sd;
    logic [2:0]  ctl;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic v, input logic [4:0] c,
                              input logic k, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] sd, input logic [2:0] ctl,
                              input logic [4:0] rd);
    exp_t e;
    e.hold = h; e.valid = v; e.ctrl = c; e.chk = k;
    e.a1 = a1; e.a2 = a2; e.sd = sd; e.ctl = ctl; e.rd = rd;
    return e;
  endfunction

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [2:0] ctl, input logic sa, input logic sb,
                          input logic [4:0] ctrl);
    bus.id_valid       = v;
    bus.id_pc          = pc;
    bus.id_rs1_data    = r1d;
    bus.id_rs2_data    = r2d;
    bus.id_imm         = imm;
    bus.id_rs1         = rs1;
    bus.id_rs2         = rs2;
    bus.id_rd          = rd;
    bus.id_alu_control = ctl;
    bus.id_src_a_pc    = sa;
    bus.id_src_b_imm   = sb;
    {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump} = ctrl;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exm_reg_write = erw;
    bus.exm_rd        = erd;
    bus.exm_result    = eres;
    bus.mwb_reg_write = mrw;
    bus.mwb_rd        = mrd;
    bus.mwb_result    = mres;
  endtask

  function automatic logic [4:0] ex_ctrl_bits();
    return {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_jump};
  endfunction

  // One clock: apply stall/flush, check hold_front, queue the expectation,
  // take the edge, then pop and compare the EX-side outputs.
  task automatic cycle(input logic st, input logic fl, input exp_t e);
    exp_t x;
    bus.stall = st;
    bus.flush = fl;
    #1;
    check("hold_front", bus.hold_front, e.hold);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    x = sb_q.pop_front();
    check("ex_valid", bus.ex_valid, x.valid);
    check("ex_ctrl", ex_ctrl_bits(), x.ctrl);
    if (x.chk) begin
      check("alu_input_1", bus.alu_input_1, x.a1);
      check("alu_input_2", bus.alu_input_2, x.a2);
      check("ex_store_data", bus.ex_store_data, x.sd);
      check("alu_control", bus.alu_control, x.ctl);
      check("ex_rd", bus.ex_rd, x.rd);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, bus.ex_valid, 1'b0);
    check({tag, "_ctrl"}, ex_ctrl_bits(), 5'b0);
    check({tag, "_alu_control"}, bus.alu_control, 3'b000);
    check({tag, "_hold_front"}, bus.hold_front, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 5'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Power-on reset
    #3;
    check_reset_state("por");
    check("por_ex_pc", bus.ex_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Pass-through, no forwarding match
    drive_id(1'b1, 32'h40, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 1'b0, 5'b10000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b10000, 1'b1, 32'd5, 32'd7, 32'd7, 3'b001, 5'd3));

    // Forward priority on rs1: EX/MEM beats MEM/WB
    set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    drive_id(1'b1, 32'h44, 32'h33, 32'h44, 32'h0, 5'd3, 5'd4, 5'd7, 3'b000, 1'b0, 1'b0, 5'b10000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b10000, 1'b1, 32'h11, 32'h44, 32'h44, 3'b000, 5'd7));
    bus.exm_reg_write = 1'b0;
    #1;
    check("fwd_mwb_rs1", bus.alu_input_1, 32'h22);
    bus.mwb_rd = 5'd4;
    #1;
    check("fwd_mwb_miss_rs1", bus.alu_input_1, 32'h33);
    check("fwd_mwb_rs2", bus.alu_input_2, 32'h22);
    check("fwd_mwb_store", bus.ex_store_data, 32'h22);
    bus.exm_reg_write = 1'b1;
    bus.exm_rd        = 5'd0;
    bus.mwb_rd        = 5'd0;
    #1;
    check("fwd_x0_rs1", bus.alu_input_1, 32'h33);
    check("fwd_x0_rs2", bus.alu_input_2, 32'h44);

    // PC / immediate select; store data still forwarded rs2
    set_fwd(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 32'h100, 32'hAA, 32'hBB, 32'hFFFF_FFFC, 5'd1, 5'd9, 5'd2, 3'b000, 1'b1, 1'b1, 5'b00100);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b00100, 1'b1, 32'h100, 32'hFFFF_FFFC, 32'h55, 3'b000, 5'd2));

    // Load-use: lw x5 then add x6,x5,x1
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 32'h104, 32'h1000, 32'h0, 32'd8, 5'd2, 5'd0, 5'd5, 3'b000, 1'b0, 1'b1, 5'b11000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b11000, 1'b1, 32'h1000, 32'd8, 32'h0, 3'b000, 5'd5));
    drive_id(1'b1, 32'h108, 32'hDEAD, 32'h10, 32'h0, 5'd5, 5'd1, 5'd6, 3'b000, 1'b0, 1'b0, 5'b10000);
    cycle(1'b0, 1'b0, mk(1'b1, 1'b0, 5'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0));
    set_fwd(1'b1, 5'd5, 32'h777, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b10000, 1'b1, 32'h777, 32'h10, 32'h10, 3'b000, 5'd6));

    // Stall for three cycles: EX contents frozen while ID changes
    drive_id(1'b1, 32'h10C, 32'h1, 32'h2, 32'h0, 5'd6, 5'd6, 5'd8, 3'b010, 1'b0, 1'b0, 5'b01000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, mk(1'b0, 1'b1, 5'b10000, 1'b1, 32'h777, 32'h10, 32'h10, 3'b000, 5'd6));
    end

    // Stall and flush together: flush wins
    cycle(1'b1, 1'b1, mk(1'b0, 1'b0, 5'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0));

    // Flush suppresses hold_front on a load-use pair and bubbles EX
    drive_id(1'b1, 32'h104, 32'h1000, 32'h0, 32'd8, 5'd2, 5'd0, 5'd5, 3'b000, 1'b0, 1'b1, 5'b11000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b11000, 1'b1, 32'h1000, 32'd8, 32'h0, 3'b000, 5'd5));
    drive_id(1'b1, 32'h108, 32'hDEAD, 32'h10, 32'h0, 5'd5, 5'd1, 5'd6, 3'b000, 1'b0, 1'b0, 5'b10000);
    cycle(1'b0, 1'b1, mk(1'b0, 1'b0, 5'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0));

    // Load to x0 never creates a load-use hazard
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 32'h200, 32'h3000, 32'h0, 32'd4, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 5'b11000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b11000, 1'b1, 32'h3000, 32'd4, 32'h0, 3'b000, 5'd0));
    drive_id(1'b1, 32'h204, 32'h0, 32'h99, 32'h0, 5'd0, 5'd3, 5'd6, 3'b101, 1'b0, 1'b0, 5'b10000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b10000, 1'b1, 32'h0, 32'h99, 32'h99, 3'b101, 5'd6));

    // Control bits gated by id_valid; branch/jump pass when valid
    drive_id(1'b0, 32'h208, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd9, 3'b100, 1'b0, 1'b0, 5'b11111);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b0, 5'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0));
    drive_id(1'b1, 32'h300, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd0, 3'b100, 1'b0, 1'b0, 5'b00011);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b00011, 1'b1, 32'h1, 32'h2, 32'h2, 3'b100, 5'd0));

    // Reset mid-operation with a live load-use hazard and a stall
    drive_id(1'b1, 32'h104, 32'h1000, 32'h0, 32'd8, 5'd2, 5'd0, 5'd5, 3'b011, 1'b0, 1'b1, 5'b11000);
    cycle(1'b0, 1'b0, mk(1'b0, 1'b1, 5'b11000, 1'b1, 32'h1000, 32'd8, 32'h0, 3'b011, 5'd5));
    drive_id(1'b1, 32'h108, 32'hDEAD, 32'h10, 32'h0, 5'd1, 5'd5, 5'd6, 3'b000, 1'b0, 1'b0, 5'b10000);
    bus.stall = 1'b1;
    #1;
    check("pre_reset_hold_front", bus.hold_front, 1'b1);
    rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rst       = 1'b1;
    bus.stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
